// File: rtl/ac_pkg.sv
// Shared state type and width helpers for the air-conditioner thermostat controller.
package ac_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        DRIP   = 1'b1
    } state_t;

    localparam int unsigned TEMP_W_DEF = 3;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ac_tick_gen.sv
// Control-tick divider: emits a one-cycle registered pulse every TICK_DIV cycles of clk_2.
module ac_tick_gen
    import ac_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk_2,
    input  logic reset,
    output logic tick
);

    localparam int unsigned      DIV_W    = width_for(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    always_comb begin
        div_d  = div_q + 1'b1;
        tick_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ac_thermostat_ctrl.sv
// Air-conditioner controller: saturating setpoint, slewing actual temperature and drip FSM.
// Optional sticky drip-timeout alarm is built when AC_DRIP_ALARM_EN is defined.
module ac_thermostat_ctrl
    import ac_pkg::*;
#(
    parameter int unsigned TEMP_W       = TEMP_W_DEF,
    parameter int unsigned TEMP_MIN     = 0,
    parameter int unsigned TEMP_MAX     = 7,
    parameter int unsigned TEMP_INIT    = 0,
    parameter int unsigned TICK_DIV     = 2,
    parameter int unsigned DRIP_AFTER   = 10,
    parameter int unsigned DRIP_HOLD    = 4,
    parameter int unsigned DRIP_TIMEOUT = 16
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [TEMP_W-1:0] temp_target,
    output logic [TEMP_W-1:0] temp_actual,
    output logic              dripping,
    output logic              tick,
    output logic              alarm
);

    localparam int unsigned       CNT_W      = width_for(max2(DRIP_AFTER, DRIP_HOLD));
    localparam logic [TEMP_W-1:0] T_MIN      = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] T_MAX      = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] T_INIT     = TEMP_W'(TEMP_INIT);
    localparam logic [CNT_W-1:0]  AFTER_LAST = CNT_W'(DRIP_AFTER - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(DRIP_HOLD - 1);

    logic              tick_w;
    logic [TEMP_W-1:0] target_q, target_d;
    logic [TEMP_W-1:0] actual_q, actual_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    ac_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_2 (clk_2),
        .reset (reset),
        .tick  (tick_w)
    );

    always_comb begin
        target_d = target_q;
        if (tick_w) begin
            if (inc && !dec && (target_q < T_MAX)) begin
                target_d = target_q + 1'b1;
            end else if (dec && !inc && (target_q > T_MIN)) begin
                target_d = target_q - 1'b1;
            end
        end
    end

    // Actual chases the pre-update setpoint, so a button press shows up one tick later.
    always_comb begin
        actual_d = actual_q;
        if (tick_w) begin
            if (actual_q < target_q) begin
                actual_d = actual_q + 1'b1;
            end else if (actual_q > target_q) begin
                actual_d = actual_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_w) begin
            unique case (state_q)
                NORMAL: begin
                    if (cnt_q == AFTER_LAST) begin
                        state_d = DRIP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIP: begin
                    // Only ticks at full drain temperature make progress; others keep it.
                    if (actual_q == T_MAX) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = NORMAL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            target_q <= T_INIT;
            actual_q <= T_INIT;
            state_q  <= NORMAL;
            cnt_q    <= '0;
        end else begin
            target_q <= target_d;
            actual_q <= actual_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef AC_DRIP_ALARM_EN
    localparam int unsigned     DT_W     = width_for(DRIP_TIMEOUT);
    localparam logic [DT_W-1:0] DT_LIMIT = DT_W'(DRIP_TIMEOUT);

    logic [DT_W-1:0] dtime_q, dtime_d;
    logic            alarm_q, alarm_d;

    // dtime counts ticks spent in DRIP, saturating at the limit; alarm latches until reset.
    always_comb begin
        dtime_d = dtime_q;
        alarm_d = alarm_q;
        if (tick_w) begin
            if (state_d != DRIP) begin
                dtime_d = '0;
            end else if ((state_q == DRIP) && (dtime_q != DT_LIMIT)) begin
                dtime_d = dtime_q + 1'b1;
            end
        end
        if (dtime_d == DT_LIMIT) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            dtime_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            dtime_q <= dtime_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_timeout;
    assign unused_timeout = (DRIP_TIMEOUT != 0);
    assign alarm          = 1'b0;
`endif

    assign temp_target = target_q;
    assign temp_actual = actual_q;
    assign dripping    = (state_q == DRIP);
    assign tick        = tick_w;

endmodule
